// File: rtl/me_word_tx_if.sv
// me_word_tx_if: block-input, schedule-output and status signals of the message word transmitter
interface me_word_tx_if #(parameter int DATA_WIDTH = 32);
    logic                     blk_valid_in;
    logic [16*DATA_WIDTH-1:0] blk_data_in;
    logic                     blk_ready_out;
    logic                     me_dv_in;
    logic                     start_out;
    logic [4:0]               Rx_core_count_out;
    logic [DATA_WIDTH-1:0]    data_out;
    logic [1:0]               o_FSM_state;
    logic                     tx_done_out;
    logic                     err_out;
    modport slave (
        input  blk_valid_in, blk_data_in, me_dv_in,
        output blk_ready_out, start_out, Rx_core_count_out, data_out, o_FSM_state, tx_done_out, err_out
    );
    modport master (
        output blk_valid_in, blk_data_in, me_dv_in,
        input  blk_ready_out, start_out, Rx_core_count_out, data_out, o_FSM_state, tx_done_out, err_out
    );
endinterface

// File: rtl/me_word_tx.sv
// me_word_tx: streams a captured 16-word block to the schedule block and waits for its completion pulse
module me_word_tx #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic         clk,
    input logic         rst,
    me_word_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, WAIT_ME = 2'b10, DONE = 2'b11} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] blk_buf [16];
    logic [4:0]            cnt;
    logic [7:0]            tmo;
    logic                  start_q;
    logic                  done_q;
    logic                  err_q;
    logic [4:0]            idx_q;
    logic [DATA_WIDTH-1:0] data_q;
    assign bus.blk_ready_out     = state == IDLE;
    assign bus.o_FSM_state       = state;
    assign bus.start_out         = start_q;
    assign bus.tx_done_out       = done_q;
    assign bus.err_out           = err_q;
    assign bus.Rx_core_count_out = idx_q;
    assign bus.data_out          = data_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            for (int i = 0; i < 16; i++) blk_buf[i] <= '0;
            cnt     <= '0;
            tmo     <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: if (bus.blk_valid_in) begin
                    for (int i = 0; i < 16; i++) blk_buf[i] <= bus.blk_data_in[(15-i)*DATA_WIDTH +: DATA_WIDTH];
                    cnt   <= '0;
                    state <= SEND;
                end
                SEND: begin
                    data_q  <= blk_buf[cnt[3:0]];
                    idx_q   <= cnt;
                    start_q <= 1'b1;
                    cnt     <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        tmo   <= '0;
                        state <= WAIT_ME;
                    end
                end
                // completion wins over a timeout landing on the same cycle
                WAIT_ME: if (bus.me_dv_in) begin
                    done_q <= 1'b1;
                    state  <= DONE;
                end else if (tmo == 8'(TIMEOUT_CYCLES - 1)) begin
                    err_q <= 1'b1;
                    state <= IDLE;
                end else begin
                    tmo <= tmo + 8'd1;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_me_word_tx.sv
// tb_me_word_tx: scoreboard-driven bench for the message word transmitter
module tb_me_word_tx;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    typedef struct {logic [4:0] idx; logic [31:0] data;} exp_t;
    exp_t sb [$];
    exp_t e;
    me_word_tx_if #(.DATA_WIDTH(32)) ba ();
    me_word_tx_if #(.DATA_WIDTH(32)) bt ();
    me_word_tx #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(ba));
    me_word_tx #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(10)) dut_t (.clk(clk), .rst(rst), .bus(bt));
    always #5 clk = ~clk;

    task automatic load_block(input logic [31:0] w [16]);
        for (int i = 0; i < 16; i++) begin
            ba.blk_data_in[(15-i)*32 +: 32] = w[i];
            sb.push_back('{idx: 5'(i), data: w[i]});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ba.blk_valid_in = 1'b0; ba.blk_data_in = '0; ba.me_dv_in = 1'b0;
        bt.blk_valid_in = 1'b0; bt.blk_data_in = '0; bt.me_dv_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ba.o_FSM_state !== 2'b00) begin fails++; $display("FAIL reset_state: got %b want 00", ba.o_FSM_state); end
        checks++; if (ba.blk_ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ba.blk_ready_out); end
        checks++; if ({ba.start_out, ba.tx_done_out, ba.err_out} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b want 000", {ba.start_out, ba.tx_done_out, ba.err_out}); end
        checks++; if (ba.data_out !== 32'h0 || ba.Rx_core_count_out !== 5'd0) begin fails++; $display("FAIL reset_data: got idx=%0d data=%h want 0/0", ba.Rx_core_count_out, ba.data_out); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ba.o_FSM_state !== 2'b00 || ba.blk_ready_out !== 1'b1) begin fails++; $display("FAIL post_reset_idle: got state=%b ready=%b want 00/1", ba.o_FSM_state, ba.blk_ready_out); end
    endtask

    task automatic test_index_words;
        logic [31:0] w [16];
        for (int i = 0; i < 16; i++) w[i] = 32'(i);
        load_block(w);
        ba.blk_valid_in = 1'b1;
        @(negedge clk);
        ba.blk_valid_in = 1'b0;
        checks++; if (ba.o_FSM_state !== 2'b01 || ba.blk_ready_out !== 1'b0 || ba.start_out !== 1'b0) begin fails++; $display("FAIL accept: got state=%b ready=%b start=%b want 01/0/0", ba.o_FSM_state, ba.blk_ready_out, ba.start_out); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin fails++; $display("FAIL idx_word%0d: scoreboard empty", k); end
            else begin
                e = sb.pop_front();
                if (ba.start_out !== 1'b1 || ba.Rx_core_count_out !== e.idx || ba.data_out !== e.data) begin fails++; $display("FAIL idx_word%0d: got start=%b idx=%0d data=%h want 1/%0d/%h", k, ba.start_out, ba.Rx_core_count_out, ba.data_out, e.idx, e.data); end
            end
        end
        @(negedge clk);
        checks++; if (ba.start_out !== 1'b0 || ba.o_FSM_state !== 2'b10 || ba.Rx_core_count_out !== 5'd15 || ba.data_out !== 32'hF) begin fails++; $display("FAIL enter_wait: got start=%b state=%b idx=%0d data=%h want 0/10/15/f", ba.start_out, ba.o_FSM_state, ba.Rx_core_count_out, ba.data_out); end
    endtask

    task automatic test_done;
        int bad = 0;
        repeat (47) begin
            @(negedge clk);
            if (ba.o_FSM_state !== 2'b10 || ba.start_out !== 1'b0 || ba.tx_done_out !== 1'b0 || ba.err_out !== 1'b0 || ba.Rx_core_count_out !== 5'd15) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL wait_hold: %0d bad cycles want 0", bad); end
        ba.me_dv_in = 1'b1;
        @(negedge clk);
        ba.me_dv_in = 1'b0;
        checks++; if (ba.o_FSM_state !== 2'b11 || ba.tx_done_out !== 1'b1 || ba.err_out !== 1'b0) begin fails++; $display("FAIL done_pulse: got state=%b done=%b err=%b want 11/1/0", ba.o_FSM_state, ba.tx_done_out, ba.err_out); end
        @(negedge clk);
        checks++; if (ba.o_FSM_state !== 2'b00 || ba.tx_done_out !== 1'b0 || ba.blk_ready_out !== 1'b1) begin fails++; $display("FAIL done_to_idle: got state=%b done=%b ready=%b want 00/0/1", ba.o_FSM_state, ba.tx_done_out, ba.blk_ready_out); end
        ba.me_dv_in = 1'b1;
        @(negedge clk);
        ba.me_dv_in = 1'b0;
        @(negedge clk);
        checks++; if (ba.o_FSM_state !== 2'b00 || ba.tx_done_out !== 1'b0 || ba.err_out !== 1'b0) begin fails++; $display("FAIL idle_ignores_dv: got state=%b done=%b err=%b want 00/0/0", ba.o_FSM_state, ba.tx_done_out, ba.err_out); end
    endtask

    task automatic test_timeout;
        int bad = 0;
        bt.blk_data_in = {16{32'hA5A5_0000}};
        bt.blk_valid_in = 1'b1;
        @(negedge clk);
        bt.blk_valid_in = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bt.err_out !== 1'b0 || bt.tx_done_out !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL timeout_early: %0d early pulses want 0", bad); end
        @(negedge clk);
        checks++; if (bt.err_out !== 1'b1 || bt.o_FSM_state !== 2'b00 || bt.tx_done_out !== 1'b0) begin fails++; $display("FAIL timeout_err: got err=%b state=%b done=%b want 1/00/0", bt.err_out, bt.o_FSM_state, bt.tx_done_out); end
        @(negedge clk);
        checks++; if (bt.err_out !== 1'b0 || bt.o_FSM_state !== 2'b00) begin fails++; $display("FAIL timeout_one_shot: got err=%b state=%b want 0/00", bt.err_out, bt.o_FSM_state); end
    endtask

    task automatic test_reset_mid_send;
        logic [31:0] w [16];
        int bad = 0;
        for (int i = 0; i < 16; i++) w[i] = $urandom;
        load_block(w);
        ba.blk_valid_in = 1'b1;
        @(negedge clk);
        ba.blk_valid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin fails++; $display("FAIL rst_word%0d: scoreboard empty", k); end
            else begin
                e = sb.pop_front();
                if (ba.start_out !== 1'b1 || ba.Rx_core_count_out !== e.idx || ba.data_out !== e.data) begin fails++; $display("FAIL rst_word%0d: got start=%b idx=%0d data=%h want 1/%0d/%h", k, ba.start_out, ba.Rx_core_count_out, ba.data_out, e.idx, e.data); end
            end
        end
        rst = 1'b1;
        #1;
        sb.delete();
        checks++; if ({ba.start_out, ba.tx_done_out, ba.err_out} !== 3'b000 || ba.data_out !== 32'h0 || ba.Rx_core_count_out !== 5'd0 || ba.o_FSM_state !== 2'b00) begin fails++; $display("FAIL rst_async: got start=%b done=%b err=%b idx=%0d data=%h state=%b want all 0", ba.start_out, ba.tx_done_out, ba.err_out, ba.Rx_core_count_out, ba.data_out, ba.o_FSM_state); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ba.blk_ready_out !== 1'b1 || ba.o_FSM_state !== 2'b00) begin fails++; $display("FAIL rst_release: got ready=%b state=%b want 1/00", ba.blk_ready_out, ba.o_FSM_state); end
        repeat (20) begin
            @(negedge clk);
            if (ba.start_out !== 1'b0 || ba.tx_done_out !== 1'b0 || ba.err_out !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL rst_no_resume: %0d active cycles want 0", bad); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] wa [16];
        logic [31:0] wb [16];
        for (int i = 0; i < 16; i++) begin wa[i] = 32'hA000_0000 + 32'(i); wb[i] = 32'hB000_0000 + 32'(i); end
        load_block(wa);
        ba.blk_valid_in = 1'b1;
        @(negedge clk);
        load_block(wb);
        for (int k = 0; k < 32; k++) begin
            if (k == 16) begin
                repeat (3) @(negedge clk);
                ba.me_dv_in = 1'b1;
                @(negedge clk);
                ba.me_dv_in = 1'b0;
                checks++; if (ba.tx_done_out !== 1'b1) begin fails++; $display("FAIL b2b_done_a: got %b want 1", ba.tx_done_out); end
                @(negedge clk);
                checks++; if (ba.o_FSM_state !== 2'b00 || ba.start_out !== 1'b0) begin fails++; $display("FAIL b2b_gap_idle: got state=%b start=%b want 00/0", ba.o_FSM_state, ba.start_out); end
                @(negedge clk);
                ba.blk_valid_in = 1'b0;
                checks++; if (ba.o_FSM_state !== 2'b01 || ba.start_out !== 1'b0) begin fails++; $display("FAIL b2b_accept: got state=%b start=%b want 01/0", ba.o_FSM_state, ba.start_out); end
            end
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin fails++; $display("FAIL b2b_word%0d: scoreboard empty", k); end
            else begin
                e = sb.pop_front();
                if (ba.start_out !== 1'b1 || ba.Rx_core_count_out !== e.idx || ba.data_out !== e.data) begin fails++; $display("FAIL b2b_word%0d: got start=%b idx=%0d data=%h want 1/%0d/%h", k, ba.start_out, ba.Rx_core_count_out, ba.data_out, e.idx, e.data); end
            end
        end
        @(negedge clk);
        ba.me_dv_in = 1'b1;
        @(negedge clk);
        ba.me_dv_in = 1'b0;
        checks++; if (ba.tx_done_out !== 1'b1 || ba.o_FSM_state !== 2'b11) begin fails++; $display("FAIL b2b_done_b: got done=%b state=%b want 1/11", ba.tx_done_out, ba.o_FSM_state); end
        @(negedge clk);
    endtask

    task automatic test_abc;
        logic [31:0] w [16];
        for (int i = 0; i < 16; i++) w[i] = 32'h0;
        w[0] = 32'h6162_6380;
        w[15] = 32'h0000_0018;
        load_block(w);
        ba.blk_valid_in = 1'b1;
        @(negedge clk);
        ba.blk_valid_in = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (sb.size() == 0) begin fails++; $display("FAIL abc_word%0d: scoreboard empty", k); end
            else begin
                e = sb.pop_front();
                if (ba.start_out !== 1'b1 || ba.Rx_core_count_out !== e.idx || ba.data_out !== e.data) begin fails++; $display("FAIL abc_word%0d: got start=%b idx=%0d data=%h want 1/%0d/%h", k, ba.start_out, ba.Rx_core_count_out, ba.data_out, e.idx, e.data); end
            end
            ba.me_dv_in = (k == 3);
        end
        ba.me_dv_in = 1'b0;
        @(negedge clk);
        checks++; if (ba.o_FSM_state !== 2'b10 || ba.data_out !== 32'h18 || ba.tx_done_out !== 1'b0) begin fails++; $display("FAIL abc_wait: got state=%b data=%h done=%b want 10/18/0", ba.o_FSM_state, ba.data_out, ba.tx_done_out); end
        ba.me_dv_in = 1'b1;
        @(negedge clk);
        ba.me_dv_in = 1'b0;
        checks++; if (ba.tx_done_out !== 1'b1 || ba.err_out !== 1'b0) begin fails++; $display("FAIL abc_done: got done=%b err=%b want 1/0", ba.tx_done_out, ba.err_out); end
        @(negedge clk);
        checks++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_drained: %0d left want 0", sb.size()); end
    endtask

    initial begin
        test_reset;
        test_index_words;
        test_done;
        test_timeout;
        test_reset_mid_send;
        test_back_to_back;
        test_abc;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/me_word_tx.md
ME_WORD_TX -- requirements
Module: me_word_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of each message word sent to the schedule block.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles to wait for schedule completion (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; one clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port blk_valid_in  input  1  upstream 512-bit block available.
REQ-006 SHALL have port blk_data_in  input  16*DATA_WIDTH  message block; word 0 = most-significant DATA_WIDTH bits.
REQ-007 SHALL have port blk_ready_out  output  1  block can be accepted this cycle.
REQ-008 SHALL have port me_dv_in  input  1  schedule block finished (its W[63] valid pulse).
REQ-009 SHALL have port start_out  output  1  word-valid strobe to schedule block.
REQ-010 SHALL have port Rx_core_count_out  output  5  index (0..15) of word on data_out.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  message word.
REQ-012 SHALL have port o_FSM_state  output  2  current state encoding.
REQ-013 SHALL have port tx_done_out  output  1  one-cycle pulse: block fully processed.
REQ-014 SHALL have port err_out  output  1  one-cycle pulse: schedule timeout.

Function
REQ-015 SHALL implement FSM IDLE=2'b00, SEND=2'b01, WAIT_ME=2'b10, DONE=2'b11, reported on o_FSM_state.
REQ-016 SHALL drive blk_ready_out high only in IDLE (combinational from state).
REQ-017 SHALL capture blk_data_in into a 16-word buffer on the edge where blk_valid_in && blk_ready_out, clear word counter, go to SEND.
REQ-018 SHALL, in SEND, present word k on registered data_out with Rx_core_count_out=k and start_out=1 for exactly one cycle each, k=0..15 consecutively, no gaps.
REQ-019 SHALL have latency: handshake at edge T -> word 0 visible after edge T+1; word 15 after edge T+16; start_out low after edge T+17.
REQ-020 SHALL transition SEND->WAIT_ME after issuing word 15; counter 5-bit, SHALL NOT wrap to 0 and resend.
REQ-021 SHALL, in WAIT_ME, hold start_out=0, data_out and Rx_core_count_out at last values, and count cycles in an 8-bit timeout counter cleared on WAIT_ME entry.
REQ-022 SHALL go WAIT_ME->DONE when me_dv_in=1; DONE lasts one cycle with tx_done_out=1, then IDLE.
REQ-023 SHALL, if timeout counter reaches TIMEOUT_CYCLES with me_dv_in=0, pulse err_out one cycle and go directly to IDLE (no tx_done_out).
REQ-024 SHALL give me_dv_in priority when it coincides with the timeout cycle: DONE, no err_out.
REQ-025 SHALL ignore me_dv_in in IDLE, SEND and DONE (no state change, no pulses).
REQ-026 SHALL ignore blk_valid_in and leave buffer unchanged while not in IDLE.
REQ-027 SHALL allow back-to-back blocks: blk_valid_in held high accepted in the IDLE cycle right after DONE.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, buffer, word counter, timeout counter, data_out, Rx_core_count_out to 0, start_out, tx_done_out, err_out to 0.
REQ-029 SHALL, on rst asserted mid-SEND or mid-WAIT_ME, abort immediately; no further words, no done/err pulse; first post-reset cycle is IDLE with blk_ready_out=1.

Verification
REQ-030 SHALL cover: block words 0x00000000..0x0000000F, valid one cycle -> start_out high 16 consecutive cycles, Rx_core_count_out 0..15, data_out equals index, then WAIT_ME.
REQ-031 SHALL cover: me_dv_in pulsed 49 cycles after word 15 -> tx_done_out pulses once, return to IDLE, err_out stays 0.
REQ-032 SHALL cover: me_dv_in never asserted, TIMEOUT_CYCLES=10 -> err_out pulses once 10 cycles after WAIT_ME entry, state IDLE, no tx_done_out.
REQ-033 SHALL cover: rst asserted during word 7 -> all outputs 0 immediately, no word 8, blk_ready_out=1 after release.
REQ-034 SHALL cover: blk_valid_in held high with two different blocks, me_dv_in returned each time -> two complete 16-word bursts, second starts 2 cycles after first tx_done_out, correct data both.
REQ-035 SHALL cover: SHA-256 "abc" padded block (word0=0x61626380, word15=0x00000018) -> data_out sequence matches exactly, word 0 first.
